// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive path.
// Holds the receiver state encoding, default sizes and bit-level helpers.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_t;

    localparam int DATA_BITS_DEF   = 8;
    localparam int SYNC_STAGES_DEF = 2;
    localparam int MIN_BIT_TIME    = 4;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // red is the XOR of the data bits; odd selects odd parity.
    function automatic logic par_mismatch(input logic red, input logic pbit,
                                          input logic odd);
        return (red ^ pbit) != odd;
    endfunction

endpackage

// File: rtl/uart_sync_edge.sv
// Multi-flop synchroniser with falling-edge detect on the synchronised line.
// Resets to the idle-high level so releasing reset never looks like an edge.
module uart_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic rxs,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign rxs  = sync_q[STAGES-1];
    assign fall = prev_q & ~rxs;

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: start detect, 3-sample majority vote per bit,
// optional parity, framing and break detection with single-cycle strobes.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int DATA_BITS   = DATA_BITS_DEF
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [15:0]          BIT_TIME,
    input  logic                 PARITY_EN,
    input  logic                 PARITY_ODD,
    input  logic                 RX,
    output logic [DATA_BITS-1:0] DATA,
    output logic                 EN,
    output logic                 PARITY_ERR,
    output logic                 FRAME_ERR,
    output logic                 BREAK,
    output logic                 IDLE
);

    localparam int BCW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    rx_state_t state_q, state_d;

    logic                 rxs, fall;
    logic [15:0]          bt_q, cnt_q, half;
    logic [BCW-1:0]       bitcnt_q;
    logic [DATA_BITS-1:0] sh_q, data_q;
    logic                 s0_q, s1_q, pen_q, podd_q, mism_q;
    logic                 en_q, perr_q, ferr_q, brk_q;
    logic                 en_d, perr_d, ferr_d, brk_d;
    logic                 at_lo, at_mid, at_dec, at_last, vote, last_bit;

    uart_sync_edge #(.STAGES(SYNC_STAGES)) u_sync (
        .clk  (CLK),
        .rst  (RESET),
        .din  (RX),
        .rxs  (rxs),
        .fall (fall)
    );

    assign half     = bt_q >> 1;
    assign at_lo    = cnt_q == half - 16'd1;
    assign at_mid   = cnt_q == half;
    assign at_dec   = cnt_q == half + 16'd1;
    assign at_last  = cnt_q == bt_q - 16'd1;
    assign vote     = maj3(s0_q, s1_q, rxs);
    assign last_bit = bitcnt_q == BCW'(DATA_BITS - 1);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:
                if (fall) state_d = ST_START;
            ST_START:
                if (at_dec && vote) state_d = ST_IDLE;
                else if (at_last)   state_d = ST_DATA;
            ST_DATA:
                if (at_last && last_bit)
                    state_d = pen_q ? ST_PARITY : ST_STOP;
            ST_PARITY:
                if (at_last) state_d = ST_STOP;
            ST_STOP:
                // The wrap escape only matters for unsupported tiny bit times.
                if (at_dec)       state_d = vote ? ST_IDLE : ST_BRK_WAIT;
                else if (at_last) state_d = ST_IDLE;
            ST_BRK_WAIT:
                if (rxs) state_d = ST_IDLE;
            default:
                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        en_d   = 1'b0;
        perr_d = 1'b0;
        ferr_d = 1'b0;
        brk_d  = 1'b0;
        if (state_q == ST_STOP && at_dec) begin
            en_d   = vote;
            perr_d = vote & mism_q;
            ferr_d = ~vote;
            brk_d  = ~vote & (sh_q == '0);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            bt_q     <= '0;
            cnt_q    <= '0;
            bitcnt_q <= '0;
            sh_q     <= '0;
            data_q   <= '0;
            s0_q     <= 1'b1;
            s1_q     <= 1'b1;
            pen_q    <= 1'b0;
            podd_q   <= 1'b0;
            mism_q   <= 1'b0;
            en_q     <= 1'b0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
            brk_q    <= 1'b0;
        end else begin
            en_q   <= en_d;
            perr_q <= perr_d;
            ferr_q <= ferr_d;
            brk_q  <= brk_d;
            if (en_d)   data_q <= sh_q;
            if (at_lo)  s0_q   <= rxs;
            if (at_mid) s1_q   <= rxs;
            if (state_q == ST_IDLE) begin
                cnt_q    <= '0;
                bitcnt_q <= '0;
                mism_q   <= 1'b0;
                if (fall) begin
                    bt_q   <= BIT_TIME;
                    pen_q  <= PARITY_EN;
                    podd_q <= PARITY_ODD;
                end
            end else begin
                cnt_q <= at_last ? 16'd0 : cnt_q + 16'd1;
            end
            if (state_q == ST_DATA) begin
                if (at_dec)  sh_q     <= DATA_BITS'({vote, sh_q} >> 1);
                if (at_last) bitcnt_q <= bitcnt_q + BCW'(1);
            end
            if (state_q == ST_PARITY && at_dec)
                mism_q <= par_mismatch(^sh_q, vote, podd_q);
        end
    end

    assign DATA       = data_q;
    assign EN         = en_q;
    assign PARITY_ERR = perr_q;
    assign FRAME_ERR  = ferr_q;
    assign BREAK      = brk_q;
    assign IDLE       = (state_q == ST_IDLE) & rxs;

endmodule

// File: tb/tb_uart_rx_os.sv
// Scoreboard bench for uart_rx_os: frames are modelled at byte level,
// expectations queued at send time and matched by an output monitor.
module tb_uart_rx_os;

    logic        CLK = 1'b0;
    logic        RESET, PARITY_EN, PARITY_ODD, RX;
    logic [15:0] BIT_TIME;
    logic [7:0]  DATA;
    logic        EN, PARITY_ERR, FRAME_ERR, BREAK, IDLE;

    always #5 CLK = ~CLK;

    uart_rx_os #(.SYNC_STAGES(2), .DATA_BITS(8)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .BIT_TIME   (BIT_TIME),
        .PARITY_EN  (PARITY_EN),
        .PARITY_ODD (PARITY_ODD),
        .RX         (RX),
        .DATA       (DATA),
        .EN         (EN),
        .PARITY_ERR (PARITY_ERR),
        .FRAME_ERR  (FRAME_ERR),
        .BREAK      (BREAK),
        .IDLE       (IDLE)
    );

    typedef struct {
        bit         ferr;
        logic [7:0] data;
        bit         perr;
        bit         brk;
    } exp_t;

    exp_t       q[$];
    exp_t       mon_e;
    logic [7:0] last_good;
    int         n_chk  = 0;
    int         n_pass = 0;
    int         cyc    = 0;
    int         en_cyc = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                      nm, act, exp, cyc);
    endtask

    // Byte-level reference: what a correct receiver reports for one frame.
    task automatic expect_frame(input logic [7:0] d, input bit pen,
                                input bit podd, input bit pbit,
                                input bit stop);
        exp_t e;
        if (stop) begin
            e.ferr = 1'b0;
            e.data = d;
            e.perr = pen && ((($countones(d) + int'(pbit)) % 2) != int'(podd));
            e.brk  = 1'b0;
            last_good = d;
        end else begin
            e.ferr = 1'b1;
            e.data = last_good;
            e.perr = 1'b0;
            e.brk  = (d == 8'h00);
        end
        q.push_back(e);
    endtask

    always @(posedge CLK) begin
        #1;
        if (!RESET) begin
            if (EN || FRAME_ERR) begin
                if (EN) en_cyc = cyc;
                if (q.size() == 0) begin
                    n_chk++;
                    $display("FAIL unexpected_strobe: got EN=%0b FRAME_ERR=%0b expected none (cycle %0d)",
                             EN, FRAME_ERR, cyc);
                end else begin
                    mon_e = q.pop_front();
                    chk("en",        EN,         !mon_e.ferr);
                    chk("frame_err", FRAME_ERR,  mon_e.ferr);
                    chk("data",      DATA,       mon_e.data);
                    chk("parity",    PARITY_ERR, mon_e.perr);
                    chk("break",     BREAK,      mon_e.brk);
                end
            end else if (PARITY_ERR || BREAK) begin
                chk("orphan_flag", {PARITY_ERR, BREAK}, 0);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        step(n);
    endtask

    // Drives one frame; noise>0 flips one cycle at that offset in every bit,
    // cut>0 aborts after that many cycles.
    task automatic send(input logic [7:0] d, input bit pen, input bit pbit,
                        input bit stop, input int bt, input int noise,
                        input int cut);
        logic bits[$];
        int   n;
        n = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (pen) bits.push_back(pbit);
        bits.push_back(stop);
        foreach (bits[b]) begin
            for (int i = 0; i < bt; i++) begin
                if (cut > 0 && n == cut) return;
                RX = (noise > 0 && i == noise) ? ~bits[b] : bits[b];
                step(1);
                n++;
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    int         t0, lat, bt, h, nz;
    bit         pen, podd, pbit, stop;
    logic [7:0] d;

    initial begin
        RESET      = 1'b1;
        RX         = 1'b1;
        BIT_TIME   = 16'd16;
        PARITY_EN  = 1'b0;
        PARITY_ODD = 1'b0;
        last_good  = 8'h00;
        step(3);
        chk("rst_data",  DATA,       0);
        chk("rst_en",    EN,         0);
        chk("rst_perr",  PARITY_ERR, 0);
        chk("rst_ferr",  FRAME_ERR,  0);
        chk("rst_break", BREAK,      0);
        chk("rst_idle",  IDLE,       1);
        RESET = 1'b0;
        idle(5);

        expect_frame(8'hA5, 0, 0, 0, 1);
        t0 = cyc;
        send(8'hA5, 0, 0, 1, 16, 0, 0);
        idle(4);
        lat = en_cyc - t0;
        chk("t1_latency_window", (lat >= 155 && lat <= 158), 1);
        chk("t1_drain", q.size(), 0);

        PARITY_EN  = 1'b1;
        PARITY_ODD = 1'b0;
        expect_frame(8'h07, 1, 0, 0, 1);
        send(8'h07, 1, 0, 1, 16, 0, 0);
        idle(4);
        expect_frame(8'h07, 1, 0, 1, 1);
        send(8'h07, 1, 1, 1, 16, 0, 0);
        idle(4);
        chk("t2_drain", q.size(), 0);

        PARITY_EN = 1'b0;
        RX = 1'b0;
        step(5);
        idle(30);
        chk("t3_idle", IDLE, 1);
        chk("t3_drain", q.size(), 0);

        expect_frame(8'h3C, 0, 0, 0, 0);
        send(8'h3C, 0, 0, 0, 16, 0, 0);
        idle(20);
        chk("t4a_idle", IDLE, 1);
        expect_frame(8'h00, 0, 0, 0, 0);
        RX = 1'b0;
        step(12 * 16);
        chk("t4b_idle_low", IDLE, 0);
        idle(10);
        chk("t4b_idle_back", IDLE, 1);
        chk("t4_drain", q.size(), 0);

        expect_frame(8'h55, 0, 0, 0, 1);
        expect_frame(8'hAA, 0, 0, 0, 1);
        send(8'h55, 0, 0, 1, 16, $urandom_range(2, 10), 0);
        send(8'hAA, 0, 0, 1, 16, $urandom_range(2, 10), 0);
        idle(4);
        chk("t5_drain", q.size(), 0);

        send(8'h81, 0, 0, 1, 16, 0, 16 * 5 + 8);
        #2;
        RESET = 1'b1;
        RX    = 1'b1;
        #1;
        chk("t6_rst_data", DATA,       0);
        chk("t6_rst_en",   EN,         0);
        chk("t6_rst_perr", PARITY_ERR, 0);
        chk("t6_rst_ferr", FRAME_ERR,  0);
        chk("t6_rst_brk",  BREAK,      0);
        last_good = 8'h00;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        idle(5);
        expect_frame(8'h81, 0, 0, 0, 1);
        send(8'h81, 0, 0, 1, 16, 0, 0);
        idle(4);
        chk("t6_data", DATA, 8'h81);
        chk("t6_drain", q.size(), 0);

        for (int k = 0; k < 14; k++) begin
            bt   = $urandom_range(6, 24);
            h    = bt / 2;
            pen  = 1'($urandom_range(0, 1));
            podd = 1'($urandom_range(0, 1));
            pbit = 1'($urandom_range(0, 1));
            stop = ($urandom_range(0, 3) != 0);
            d    = (k == 5) ? 8'h00 : 8'($urandom);
            nz   = $urandom_range(2, h + 2);
            BIT_TIME   = 16'(bt);
            PARITY_EN  = pen;
            PARITY_ODD = podd;
            expect_frame(d, pen, podd, pbit, stop);
            fork
                send(d, pen, pbit, stop, bt, nz, 0);
                begin
                    repeat (3) @(posedge CLK);
                    #2;
                    BIT_TIME = 16'($urandom_range(4, 60));
                end
            join
            idle($urandom_range(3, 20));
        end
        idle(10);
        chk("rand_drain", q.size(), 0);
        chk("rand_idle", IDLE, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Oversampling UART receive front end: resynchronises the raw RX pin, detects start bits, majority-votes three samples per bit and delivers one byte per frame to the receive FIFO. Sits directly upstream of the buffered receive path. Its byte strobe drives the FIFO write enable, and its error strobes feed the sticky status flags. Adds false-start rejection, framing-error detection and break detection.

Parameters:
SYNC_STAGES, 2, number of metastability flops on RX (minimum 2).
DATA_BITS, 8, data bits per frame, sent LSB first.

Ports:
CLK  in  1  system clock.
RESET  in  1  asynchronous active-high reset.
BIT_TIME  in  16  CLK cycles per bit. Legal range is 4..65535.
PARITY_EN  in  1  frame carries a parity bit after the data bits.
PARITY_ODD  in  1  1 selects odd parity, 0 selects even parity.
RX  in  1  raw serial line, asynchronous, idle high.
DATA  out  DATA_BITS  last received byte. Held until the next EN.
EN  out  1  one-cycle strobe meaning a valid byte is on DATA.
PARITY_ERR  out  1  one-cycle strobe, coincident with EN, flagging a parity mismatch.
FRAME_ERR  out  1  one-cycle strobe flagging a stop bit sampled 0.
BREAK  out  1  one-cycle strobe: data bits all 0 and stop bit 0.
IDLE  out  1  high while in IDLE with the synchronised line high.

Behaviour:
- Reset (asynchronous): synchroniser and edge flops reset to 1, so no false start occurs on release. FSM goes to IDLE. DATA=0. EN, PARITY_ERR, FRAME_ERR and BREAK = 0. Counters = 0.
- Line handling: rxs is the SYNC_STAGES-flop synchronised RX. A falling edge on rxs (previous 1, current 0) in IDLE moves the FSM to START and latches BIT_TIME into bt_q. Later changes to BIT_TIME do not affect the frame in progress.
- Bit timer: cnt runs 0..bt_q-1 within each bit, with cnt=0 on the first cycle after the edge. Let h=bt_q>>1. rxs is sampled at cnt=h-1, h and h+1. The bit value is the 2-of-3 majority, decided at cnt=h+1.
- FSM states: IDLE, START, DATA, PARITY, STOP, BRK_WAIT.
- START: majority 1 is a false start. Go to IDLE with no strobes. Majority 0 goes to DATA when cnt wraps.
- DATA: shift each decided bit in, LSB first. bitcnt counts 0..DATA_BITS-1. After the last bit, go to PARITY if PARITY_EN, otherwise STOP.
- PARITY: compute p = XOR(data bits, parity bit). A mismatch is p != PARITY_ODD. The result is stored and reported at stop.
- STOP, majority 1: on the next edge, DATA <= shift register, EN=1, and PARITY_ERR=mismatch (0 when PARITY_EN=0). Return to IDLE immediately, at mid stop bit, so a start edge arriving early in the next frame is still caught.
- STOP, majority 0: on the next edge, FRAME_ERR=1 and EN=0, DATA unchanged. If all data bits are 0, BREAK=1 in the same cycle. Go to BRK_WAIT.
- BRK_WAIT: stay until rxs=1, then go to IDLE. A line held low produces exactly one FRAME_ERR/BREAK pair.
- Latency: EN asserts exactly 1 cycle after the stop-bit decision at cnt=h+1. That is about (DATA_BITS+1+PARITY_EN)*bt_q + h + 2 + SYNC_STAGES cycles from the RX falling edge.
- Strobes are never asserted for more than one cycle and never overlap EN, except PARITY_ERR, which is always coincident with EN.
- Reset mid-frame: the frame is discarded with no strobes. The next frame is received correctly once the line has been seen high.
- bt_q < 4 is not supported. Behaviour is undefined but must not hang; any reset recovers the block.

Decomposition:
- Shared package uart_pkg: rx_state_t enum with the six states; constants DATA_BITS_DEF=8, SYNC_STAGES_DEF=2, MIN_BIT_TIME=4.
- One sub-module, uart_sync_edge: SYNC_STAGES-flop synchroniser plus falling-edge detect. Outputs rxs and fall. Parameterised, resets to 1, and reusable for CTS.
- Majority vote and parity are small inline functions in uart_pkg.

Test Plan:
1. BIT_TIME=16, no parity, send 0xA5 with stop=1 → exactly one EN, DATA=0xA5, PARITY_ERR=0, EN about 154+SYNC cycles after the falling edge.
2. PARITY_EN=1, PARITY_ODD=0, send 0x07 with parity bit 0 (wrong; 0x07 has three 1s) → EN with DATA=0x07 and PARITY_ERR=1. Resend with parity bit 1 → EN with PARITY_ERR=0.
3. RX low for 5 cycles at BIT_TIME=16 (shorter than h+2) → no strobes, FSM back in IDLE, IDLE=1.
4. Send 0x3C with stop bit 0, then line high → FRAME_ERR=1, EN=0, BREAK=0, DATA keeps its previous value. Hold RX low for 12 bit times → one FRAME_ERR plus BREAK, IDLE=0 until RX returns high.
5. Back-to-back frames 0x55, 0xAA with no idle gap and a noise pulse of 1 cycle inside each bit → two EN strobes with DATA=0x55 then 0xAA, no errors.
6. Assert RESET during data bit 4 → all outputs 0 immediately. Next frame 0x81 is received correctly with DATA=0x81.
